// File: rtl/stop_it_fsm.sv
// Stop-it reaction game controller: arm, run the external time counter,
// judge the stop press against a latched random target, keep a win streak.
module stop_it_fsm #(
    parameter int unsigned START_DELAY = 8,
    parameter int unsigned RESULT_HOLD = 8
) (
    input  logic       clk_4_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic       stop_i,
    input  logic [4:0] rand_i,
    input  logic [4:0] time_i,
    output logic       time_en_o,
    output logic       time_rst_no,
    output logic [4:0] target_o,
    output logic [2:0] state_o,
    output logic [3:0] score_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_e;

    // Counter compares against the last cycle index so a phase lasts exactly N cycles.
    localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(RESULT_HOLD - 1);
    localparam logic [4:0] TIME_MAX   = 5'd31;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;       // shared ARMED delay / WIN-LOSE hold counter
    logic [4:0] target_q, target_d;
    logic [3:0] score_q, score_d;
    logic       go_prev_q, stop_prev_q;
    logic       go_rise, stop_rise;

    // Previous-value registers reset high so a button held through reset gives no edge.
    assign go_rise   = go_i & ~go_prev_q;
    assign stop_rise = stop_i & ~stop_prev_q;

    // State, counters and button history registers.
    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            target_q    <= 5'd0;
            score_q     <= 4'd0;
            go_prev_q   <= 1'b1;
            stop_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            score_q     <= score_d;
            go_prev_q   <= go_i;
            stop_prev_q <= stop_i;
        end
    end

    // Next-state, counter, target latch and streak update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        target_d = target_q;
        score_d  = score_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (go_rise) begin
                    target_d = rand_i;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                if (cnt_q == DELAY_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = 8'd0;
                // A stop press is judged before the timeout so a target of 31 can still win.
                if (stop_rise) begin
                    if (time_i == target_q) begin
                        state_d = S_WIN;
                        score_d = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
                    end else begin
                        state_d = S_LOSE;
                        score_d = 4'd0;
                    end
                end else if (time_i == TIME_MAX) begin
                    state_d = S_LOSE;
                    score_d = 4'd0;
                end
            end
            S_WIN, S_LOSE: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Counter controls decoded from the state register only.
    always_comb begin
        time_en_o   = (state_q == S_RUN);
        time_rst_no = (state_q == S_RUN) || (state_q == S_WIN) || (state_q == S_LOSE);
    end

    assign state_o  = state_q;
    assign target_o = target_q;
    assign score_o  = score_q;

endmodule

// File: tb/tb_stop_it_fsm.sv
// Directed bench for stop_it_fsm: full games, timeout, streak saturation, async reset.
module tb_stop_it_fsm;

    logic       clk_4_i;
    logic       rst_ni;
    logic       go_i;
    logic       stop_i;
    logic [4:0] rand_i;
    logic [4:0] time_i;
    logic       time_en_o;
    logic       time_rst_no;
    logic [4:0] target_o;
    logic [2:0] state_o;
    logic [3:0] score_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_score = 0;

    stop_it_fsm #(.START_DELAY(8), .RESULT_HOLD(8)) dut (
        .clk_4_i    (clk_4_i),
        .rst_ni     (rst_ni),
        .go_i       (go_i),
        .stop_i     (stop_i),
        .rand_i     (rand_i),
        .time_i     (time_i),
        .time_en_o  (time_en_o),
        .time_rst_no(time_rst_no),
        .target_o   (target_o),
        .state_o    (state_o),
        .score_o    (score_o)
    );

    initial clk_4_i = 1'b0;
    always #5 clk_4_i = ~clk_4_i;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4_i);
        #1;
    endtask

    // Pulse go with a target and walk through the 8 ARMED cycles into RUN.
    task automatic start_game(input logic [4:0] r);
        time_i = 5'd0;
        rand_i = r;
        go_i   = 1'b1;
        tick();
        go_i = 1'b0;
        chk("armed_target", target_o, r);
        chk("armed_state", state_o, 1);
        chk("armed_rstn", time_rst_no, 0);
        chk("armed_en", time_en_o, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("armed_hold", state_o, 1);
        end
        tick();
        chk("run_state", state_o, 2);
        chk("run_en", time_en_o, 1);
        chk("run_rstn", time_rst_no, 1);
    endtask

    // Result state lasts 8 cycles (already in its first), stop presses ignored.
    task automatic finish_result(input int st);
        chk("res_en", time_en_o, 0);
        chk("res_rstn", time_rst_no, 1);
        for (int i = 0; i < 7; i++) begin
            stop_i = (i == 2);
            tick();
            chk("res_hold", state_o, st);
        end
        stop_i = 1'b0;
        tick();
        chk("res_idle", state_o, 0);
        chk("res_score_kept", score_o, exp_score);
    endtask

    task automatic win_game(input logic [4:0] r);
        start_game(r);
        time_i = r;
        stop_i = 1'b1;
        tick();
        stop_i    = 1'b0;
        exp_score = (exp_score == 15) ? 15 : exp_score + 1;
        chk("win_state", state_o, 3);
        chk("win_score", score_o, exp_score);
        finish_result(3);
    endtask

    initial begin
        go_i   = 1'b1;
        stop_i = 1'b0;
        rand_i = 5'd0;
        time_i = 5'd0;
        rst_ni = 1'b0;
        #3;
        chk("rst_state", state_o, 0);
        chk("rst_en", time_en_o, 0);
        chk("rst_rstn", time_rst_no, 0);
        chk("rst_target", target_o, 0);
        chk("rst_score", score_o, 0);

        // go held through reset release must not start a game
        rand_i = 5'd9;
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("held_go_idle", state_o, 0);
        chk("held_go_target", target_o, 0);
        go_i = 1'b0;
        tick();

        // Game 1: target 5, stop at 5 -> win; go in RUN ignored
        start_game(5'd5);
        rand_i = 5'd9;
        go_i   = 1'b1;
        time_i = 5'd3;
        tick();
        go_i = 1'b0;
        chk("go_in_run_state", state_o, 2);
        chk("go_in_run_target", target_o, 5);
        time_i = 5'd5;
        stop_i = 1'b1;
        tick();
        stop_i    = 1'b0;
        exp_score = 1;
        chk("g1_win", state_o, 3);
        chk("g1_score", score_o, 1);
        finish_result(3);

        // Game 2: stop at 4 vs target 5 -> lose, streak cleared
        start_game(5'd5);
        time_i = 5'd4;
        stop_i = 1'b1;
        tick();
        stop_i    = 1'b0;
        exp_score = 0;
        chk("g2_lose", state_o, 4);
        chk("g2_score", score_o, 0);
        finish_result(4);

        // Game 3: no stop, counter reaches 31 -> timeout lose
        win_game(5'd2);
        start_game(5'd7);
        time_i = 5'd30;
        tick();
        chk("g3_at30", state_o, 2);
        time_i = 5'd31;
        tick();
        exp_score = 0;
        chk("g3_timeout", state_o, 4);
        chk("g3_score", score_o, 0);
        finish_result(4);

        // Game 4: target 31, stop at 31 -> stop wins over timeout
        start_game(5'd31);
        time_i = 5'd31;
        stop_i = 1'b1;
        tick();
        stop_i    = 1'b0;
        exp_score = 1;
        chk("g4_win31", state_o, 3);
        chk("g4_score", score_o, 1);
        finish_result(3);

        // 16 more wins: streak saturates at 15
        for (int g = 0; g < 16; g++) win_game(5'(g + 3));
        chk("sat_score", score_o, 15);

        // Async reset between edges during RUN
        start_game(5'd12);
        time_i = 5'd6;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_state", state_o, 0);
        chk("async_en", time_en_o, 0);
        chk("async_score", score_o, 0);
        chk("async_target", target_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", state_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stop_it_fsm.md
STOP_IT_FSM -- requirements
Module: stop_it_fsm

Interface
REQ-001 Parameter: START_DELAY, 8, cycles spent in ARMED before timing starts (range 1..255).
REQ-002 Parameter: RESULT_HOLD, 8, cycles spent in WIN/LOSE before returning to IDLE (range 1..255).
REQ-003 Port: clk_4_i  input  1  4 Hz game clock; sole clock of the block.
REQ-004 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 Port: go_i  input  1  start button, debounced, synchronous to clk_4_i.
REQ-006 Port: stop_i  input  1  stop button, debounced, synchronous to clk_4_i.
REQ-007 Port: rand_i  input  5  pseudo-random target candidate, sampled at game start.
REQ-008 Port: time_i  input  5  current value from the downstream time counter (count_o).
REQ-009 Port: time_en_o  output  1  enable to the time counter (its en_i).
REQ-010 Port: time_rst_no  output  1  active-low synchronous clear to the time counter (its rst_ni).
REQ-011 Port: target_o  output  5  latched target value.
REQ-012 Port: state_o  output  3  state code: IDLE=0, ARMED=1, RUN=2, WIN=3, LOSE=4.
REQ-013 Port: score_o  output  4  consecutive-win streak.

Function
REQ-014 Button edges SHALL be detected from registered previous values: rise = current & ~previous; no edge is reported on the cycle after reset if the button is already held.
REQ-015 IDLE: time_en_o=0, time_rst_no=0; on go_i rise, latch target_q=rand_i, clear delay counter, go to ARMED next cycle.
REQ-016 ARMED: time_en_o=0, time_rst_no=0; delay counter increments each cycle; after exactly START_DELAY cycles in ARMED go to RUN.
REQ-017 RUN: time_en_o=1, time_rst_no=1; stop_i rise on a cycle with time_i==target_q -> WIN next cycle; with time_i!=target_q -> LOSE next cycle.
REQ-018 RUN timeout: time_i==31 with no stop_i rise that cycle -> LOSE next cycle (counter never wraps to 0 during a game).
REQ-019 Simultaneous stop_i rise and time_i==31: stop evaluation takes priority (target 31 -> WIN).
REQ-020 go_i rise SHALL be ignored in every state except IDLE.
REQ-021 WIN: time_en_o=0, time_rst_no=1 (counter freezes on stopped value); score_o increments by 1 on entry, saturating at 15.
REQ-022 LOSE: time_en_o=0, time_rst_no=1; score_o cleared to 0 on entry.
REQ-023 WIN/LOSE SHALL last exactly RESULT_HOLD cycles, then return to IDLE; stop_i ignored there.
REQ-024 target_o SHALL change only on the IDLE->ARMED transition.
REQ-025 time_en_o, time_rst_no and state_o SHALL be decoded from the state register only (no input-to-output combinational path).
REQ-026 Illegal state codes (5..7) SHALL return to IDLE on the next cycle.

Reset
REQ-027 rst_ni low SHALL immediately (asynchronously) force: state IDLE, target_q=0, score=0, delay/hold counters=0, button-previous registers=1.
REQ-028 Reset asserted mid-game (any state) SHALL abandon the game; outputs take reset values without waiting for a clock edge.
REQ-029 After reset release, first state change requires a fresh go_i rise.

Verification
REQ-030 Reset, go_i pulse with rand_i=5 -> target_o=5, state ARMED for 8 cycles, RUN on 9th; time_rst_no low through ARMED.
REQ-031 RUN, stop_i rise when time_i=5, target 5 -> WIN next cycle, score 0->1, time_en_o=0, IDLE after 8 cycles.
REQ-032 RUN, stop_i rise when time_i=4, target 5 -> LOSE, score cleared to 0.
REQ-033 RUN, no stop, time_i reaches 31 -> LOSE next cycle; repeat with target 31 and stop at 31 -> WIN.
REQ-034 16 consecutive wins -> score_o saturates at 15; go_i held through reset release -> stays IDLE.
REQ-035 rst_ni pulled low between clock edges during RUN -> state_o=0, time_en_o=0, score_o=0 before next edge.
